// File: rtl/ac_mode_sequencer.sv
// ac_mode_sequencer: heater/cooler drive sequencer with min-on, dead-time and interlock.
// Optional run-time limit with sticky fault: define AC_SEQ_MAX_ON_EN.
module ac_mode_sequencer #(
   parameter int MIN_ON_CYCLES  = 8,
   parameter int MIN_OFF_CYCLES = 4,
   parameter int MAX_ON_CYCLES  = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic enable_i,
   input  logic heat_req_i,
   input  logic cool_req_i,
   output logic heater_en_o,
   output logic cooler_en_o,
   output logic busy_o,
   output logic fault_o
);

   localparam int ON_OFF_TOP =
      (MIN_ON_CYCLES > MIN_OFF_CYCLES) ? MIN_ON_CYCLES : MIN_OFF_CYCLES;
`ifdef AC_SEQ_MAX_ON_EN
   localparam int CNT_TOP =
      (MAX_ON_CYCLES > ON_OFF_TOP) ? MAX_ON_CYCLES : ON_OFF_TOP;
`else
   localparam int CNT_TOP = ON_OFF_TOP;
`endif
   localparam int CW = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;

   localparam logic [CW-1:0] ON_LAST  = CW'(MIN_ON_CYCLES - 1);
   localparam logic [CW-1:0] OFF_LAST = CW'(MIN_OFF_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HEAT,
      S_COOL,
      S_REST
   } state_t;

   state_t        state;
   state_t        state_nx;
   state_t        start_state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic          start_blk;
   logic          max_trip;
   logic          heat_rel;
   logic          cool_rel;
   logic          on_met;

   assign heat_rel = !heat_req_i || !enable_i;
   assign cool_rel = !cool_req_i || !enable_i;
   assign on_met   = (cnt >= ON_LAST);

`ifdef AC_SEQ_MAX_ON_EN
   localparam logic [CW-1:0] MAX_LAST = CW'(MAX_ON_CYCLES - 1);

   logic fault;

   assign max_trip  = ((state == S_HEAT) || (state == S_COOL))
                      && (cnt == MAX_LAST);
   assign start_blk = fault;
   assign fault_o   = fault;

   // sticky run-time fault; a low global enable acknowledges it
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fault <= 1'b0;
      end else if (!enable_i) begin
         fault <= 1'b0;
      end else if (max_trip) begin
         fault <= 1'b1;
      end
   end
`else
   logic max_on_unused;

   assign max_on_unused = (MAX_ON_CYCLES > MIN_ON_CYCLES);
   assign max_trip      = 1'b0;
   assign start_blk     = 1'b0;
   assign fault_o       = 1'b0;
`endif

   // start rule: exactly one request with the AC enabled and no fault
   always_comb begin
      start_state = S_IDLE;
      if (enable_i && !start_blk) begin
         if (heat_req_i && !cool_req_i) begin
            start_state = S_HEAT;
         end else if (cool_req_i && !heat_req_i) begin
            start_state = S_COOL;
         end
      end
   end

   // next state: hold min on-time, then rest a fixed dead-time
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            state_nx = start_state;
         end
         S_HEAT: begin
            if (max_trip || (heat_rel && on_met)) begin
               state_nx = S_REST;
            end
         end
         S_COOL: begin
            if (max_trip || (cool_rel && on_met)) begin
               state_nx = S_REST;
            end
         end
         S_REST: begin
            if (cnt == OFF_LAST) begin
               state_nx = start_state;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // shared dwell counter: cleared on each state change, saturating
   always_comb begin
      cnt_nx = cnt;
      if ((state_nx != state) || (state == S_IDLE)) begin
         cnt_nx = '0;
      end else if (cnt != CNT_MAX) begin
         cnt_nx = cnt + 1'b1;
      end
   end

   // state and counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   assign heater_en_o = (state == S_HEAT);
   assign cooler_en_o = (state == S_COOL);
   assign busy_o      = (state != S_IDLE);

endmodule

// File: tb/tb_ac_mode_sequencer.sv
// tb_ac_mode_sequencer: scoreboard bench with a cycle-level behavioural model.
// Directed scenarios followed by randomized request/enable/reset traffic.
module tb_ac_mode_sequencer;

   localparam int MIN_ON  = 8;
   localparam int MIN_OFF = 4;
   localparam int MAX_ON  = 64;

   typedef struct packed {
      logic heat;
      logic cool;
      logic busy;
      logic fault;
   } exp_t;

   logic clk = 1'b0;
   logic rst_i = 1'b0;
   logic enable_i = 1'b0;
   logic heat_req_i = 1'b0;
   logic cool_req_i = 1'b0;
   logic heater_en_o;
   logic cooler_en_o;
   logic busy_o;
   logic fault_o;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   // model: which drive is on (0 none, 1 heat, 2 cool), how long it has
   // been on, how many dead-time cycles remain, and the fault flag
   int   m_on = 0;
   int   m_ran = 0;
   int   m_rest = 0;
   bit   m_fault = 1'b0;

   ac_mode_sequencer #(
      .MIN_ON_CYCLES (MIN_ON),
      .MIN_OFF_CYCLES(MIN_OFF),
      .MAX_ON_CYCLES (MAX_ON)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .enable_i   (enable_i),
      .heat_req_i (heat_req_i),
      .cool_req_i (cool_req_i),
      .heater_en_o(heater_en_o),
      .cooler_en_o(cooler_en_o),
      .busy_o     (busy_o),
      .fault_o    (fault_o)
   );

   always #5 clk = ~clk;

   function automatic void model_start(bit e, bit h, bit c, bit f_old);
      if (e && !f_old) begin
         if (h && !c) begin
            m_on  = 1;
            m_ran = 1;
         end else if (c && !h) begin
            m_on  = 2;
            m_ran = 1;
         end
      end
   endfunction

   function automatic void model_step(bit r, bit e, bit h, bit c);
      bit f_old;
      bit own;
      bit trip;
      f_old = m_fault;
      trip  = 1'b0;
      if (r) begin
         m_on    = 0;
         m_ran   = 0;
         m_rest  = 0;
         m_fault = 1'b0;
         return;
      end
      if (m_on != 0) begin
         own = (m_on == 1) ? h : c;
`ifdef AC_SEQ_MAX_ON_EN
         trip = (m_ran == MAX_ON);
`endif
         if (trip || ((!own || !e) && m_ran >= MIN_ON)) begin
            m_on   = 0;
            m_rest = MIN_OFF;
            if (trip) m_fault = 1'b1;
         end else begin
            m_ran++;
         end
      end else if (m_rest > 0) begin
         m_rest--;
         if (m_rest == 0) model_start(e, h, c, f_old);
      end else begin
         model_start(e, h, c, f_old);
      end
      if (!e) m_fault = 1'b0;
   endfunction

   task automatic step(bit r, bit e, bit h, bit c);
      exp_t x;
      rst_i      = r;
      enable_i   = e;
      heat_req_i = h;
      cool_req_i = c;
      @(posedge clk);
      model_step(r, e, h, c);
      x.heat  = (m_on == 1);
      x.cool  = (m_on == 2);
      x.busy  = (m_on != 0) || (m_rest > 0);
      x.fault = m_fault;
      q.push_back(x);
      @(negedge clk);
   endtask

   task automatic check(string n, logic act, logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b t=%0t", n, act, exp, $time);
      end
   endtask

   // monitor: compare registered outputs away from the active edge
   always @(negedge clk) begin
      exp_t x;
      if (q.size() > 0) begin
         x = q.pop_front();
         check("heater_en", heater_en_o, x.heat);
         check("cooler_en", cooler_en_o, x.cool);
         check("busy", busy_o, x.busy);
         check("fault", fault_o, x.fault);
         check("interlock", heater_en_o & cooler_en_o, 1'b0);
      end
   end

   initial begin
      bit e;
      bit h;
      bit c;
      bit r;
      @(negedge clk);
      repeat (2) step(1, 0, 0, 0);
      // single-cycle heat pulse: min on-time then dead-time
      step(0, 1, 1, 0);
      repeat (14) step(0, 1, 0, 0);
      // long heat, drop, re-request during rest
      repeat (20) step(0, 1, 1, 0);
      step(0, 1, 0, 0);
      repeat (10) step(0, 1, 1, 0);
      repeat (12) step(0, 1, 0, 0);
      // heat to cool changeover
      repeat (10) step(0, 1, 1, 0);
      repeat (20) step(0, 1, 0, 1);
      repeat (15) step(0, 1, 0, 0);
      // conflicting requests, then disabled request
      repeat (10) step(0, 1, 1, 1);
      repeat (10) step(0, 0, 1, 0);
      repeat (5) step(0, 1, 0, 0);
      // reset in the middle of heating, then immediate restart
      repeat (3) step(0, 1, 1, 0);
      step(1, 1, 1, 0);
      repeat (12) step(0, 1, 1, 0);
      repeat (20) step(0, 1, 0, 0);
      // long hold: run-time limit when enabled, then enable drop
      repeat (100) step(0, 1, 1, 0);
      step(0, 0, 1, 0);
      repeat (20) step(0, 1, 1, 0);
      repeat (15) step(0, 1, 0, 0);
      // random traffic
      e = 1'b1;
      h = 1'b0;
      c = 1'b0;
      repeat (3000) begin
         if ($urandom_range(0, 7) == 0) h = ~h;
         if ($urandom_range(0, 9) == 0) c = ~c;
         if ($urandom_range(0, 23) == 0) e = ~e;
         r = ($urandom_range(0, 299) == 0);
         step(r, e, h, c);
      end
      repeat (5) begin
         if (q.size() != 0) @(negedge clk);
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d exp=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
